// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifetch_pkg;

    localparam int          PC_W          = 32;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FULL  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] p);
        return p & PC_ALIGN_MASK;
    endfunction

    function automatic logic pc_misaligned(input logic [PC_W-1:0] p);
        return |p[1:0];
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - memory, decoder and redirect signals of the fetch unit
interface ifetch_unit_if;
    import ifetch_pkg::*;

    logic            mem_req;
    logic [29:0]     mem_addr_I;
    logic            mem_ready;
    logic [31:0]     mem_rdata_I;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output mem_req, mem_addr_I, inst_valid, inst, inst_pc, fetch_fault,
        input  mem_ready, mem_rdata_I, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr_I, inst_valid, inst, inst_pc, fetch_fault,
        output mem_ready, mem_rdata_I, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetch FSM with redirect/drain handling
// Optional misaligned-redirect fault: define IFETCH_MISALIGN_EXC_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_pc;
    logic            pend_bad;
    logic            mem_req_q;
    logic [29:0]     mem_addr_q;
    logic            inst_valid_q;
    logic [31:0]     inst_q;
    logic [PC_W-1:0] inst_pc_q;
    logic            fault_q;

    logic [PC_W-1:0] tgt;
    logic            redir_bad;
    logic [PC_W-1:0] idle_pc;
    logic [PC_W-1:0] drain_pc;
    logic            drain_bad;

    // Low target bits never reach the PC; they only matter for the fault check.
    assign tgt = align_pc(bus.redirect_pc);
`ifdef IFETCH_MISALIGN_EXC_EN
    assign redir_bad = pc_misaligned(bus.redirect_pc);
`else
    assign redir_bad = 1'b0;
`endif

    assign idle_pc   = bus.redirect_valid ? tgt : pc_q;
    // A redirect arriving on the drain's final cycle is the newest target.
    assign drain_pc  = bus.redirect_valid ? tgt : pend_pc;
    assign drain_bad = bus.redirect_valid ? redir_bad : pend_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_q         <= RESET_PC;
            pend_pc      <= '0;
            pend_bad     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid && redir_bad) begin
                        fault_q <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        pc_q       <= idle_pc;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= idle_pc[31:2];
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        if (bus.mem_ready) begin
                            if (redir_bad) begin
                                mem_req_q <= 1'b0;
                                fault_q   <= 1'b1;
                                state     <= FAULT;
                            end else begin
                                pc_q       <= tgt;
                                mem_addr_q <= tgt[31:2];
                            end
                        end else begin
                            pend_pc  <= tgt;
                            pend_bad <= redir_bad;
                            state    <= DRAIN;
                        end
                    end else if (bus.mem_ready) begin
                        inst_q       <= bus.mem_rdata_I;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_q + 32'd4;
                        mem_req_q    <= 1'b0;
                        state        <= FULL;
                    end
                end
                FULL: begin
                    if (bus.redirect_valid) begin
                        inst_valid_q <= 1'b0;
                        if (redir_bad) begin
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            pc_q       <= tgt;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= tgt[31:2];
                            state      <= REQ;
                        end
                    end else if (bus.inst_ready) begin
                        inst_valid_q <= 1'b0;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= pc_q[31:2];
                        state        <= REQ;
                    end
                end
                DRAIN: begin
                    if (bus.mem_ready) begin
                        if (drain_bad) begin
                            mem_req_q <= 1'b0;
                            fault_q   <= 1'b1;
                            state     <= FAULT;
                        end else begin
                            pc_q       <= drain_pc;
                            mem_addr_q <= drain_pc[31:2];
                            state      <= REQ;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_pc  <= tgt;
                        pend_bad <= redir_bad;
                    end
                end
                FAULT: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr_I  = mem_addr_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.fetch_fault = fault_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 Reset rst_n is asynchronous and active-low; clock is clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_req  out  1  instruction-memory read request.
REQ-006 mem_addr_I  out  30  word address [31:2] of the request.
REQ-007 mem_ready  in  1  memory response; mem_rdata_I valid this cycle.
REQ-008 mem_rdata_I  in  32  instruction word from memory.
REQ-009 inst_valid  out  1  inst/inst_pc hold a fetched instruction for the decoder.
REQ-010 inst  out  32  instruction word for the decoder.
REQ-011 inst_pc  out  32  byte PC of inst.
REQ-012 inst_ready  in  1  decoder accepts inst this cycle.
REQ-013 redirect_valid  in  1  branch/jump resolved taken; flush and refetch.
REQ-014 redirect_pc  in  32  target byte PC.
REQ-015 fetch_fault  out  1  misaligned redirect seen (IFETCH_MISALIGN_EXC_EN only).

Function
REQ-016 FSM states: IDLE, REQ, FULL, DRAIN, FAULT.
REQ-017 IDLE: one cycle after reset release, then REQ.
REQ-018 REQ: mem_req=1 and mem_addr_I=pc[31:2]; address held stable until mem_ready.
REQ-019 REQ with mem_ready: inst<=mem_rdata_I, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^32 wrap), next FULL.
REQ-020 FULL: mem_req=0; outputs stable while inst_ready=0; on inst_ready: inst_valid<=0, next REQ.
REQ-021 Only one outstanding memory request at a time; mem_req deasserted in all states except REQ and DRAIN.
REQ-022 Redirect has priority over all other events in the same cycle.
REQ-023 Redirect in IDLE, FULL, or REQ with mem_ready: pc<=redirect_pc, inst_valid<=0, returned data discarded, next REQ.
REQ-024 Redirect in REQ without mem_ready: latch redirect_pc in pend_pc, next DRAIN; mem_addr_I unchanged.
REQ-025 DRAIN: mem_req=1 at old address; on mem_ready data discarded, pc<=pend_pc, next REQ; a newer redirect overwrites pend_pc.
REQ-026 inst_valid is never 1 while in REQ or DRAIN; an accepted inst is never re-presented.
REQ-027 Redirect to the same PC as current fetch still flushes and refetches.

Reset
REQ-028 On rst_n low: state=IDLE, pc=RESET_PC, inst_valid=0, inst=32'h0000_0013, inst_pc=0, pend_pc=0, fetch_fault=0, mem_req=0, mem_addr_I=0.
REQ-029 Reset mid-request abandons it; any later mem_ready while not in REQ/DRAIN is ignored.

Configuration
REQ-030 Macro IFETCH_MISALIGN_EXC_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, clears inst_valid, enters FAULT; FAULT holds mem_req=0 until reset; pending DRAIN completes (data discarded) before entering FAULT.
REQ-031 Macro undefined: redirect_pc[1:0] ignored (truncated), fetch_fault tied 0, FAULT unreachable.

Structure
REQ-032 Shared package ifetch_pkg: FSM state encoding, NOP constant 32'h0000_0013, PC width 32.
REQ-033 Single module; no sub-module; PC incrementer and FSM inline.

Verification
REQ-034 Reset release, mem_ready one cycle after each mem_req, inst_ready=1 -> addresses 0x0,0x1,0x2 (words); inst_pc 0x0,0x4,0x8; inst_valid pulses one per fetch.
REQ-035 mem_ready delayed 3 cycles -> mem_req and mem_addr_I stable for 4 cycles; inst captured on 4th.
REQ-036 inst_ready=0 for 5 cycles in FULL -> inst/inst_pc unchanged, mem_req=0, no new fetch.
REQ-037 redirect_valid=1, redirect_pc=0x100 during REQ without mem_ready -> DRAIN; old word discarded on mem_ready; next mem_addr_I=0x40, inst_pc=0x100.
REQ-038 redirect and mem_ready same cycle in REQ -> data dropped, next fetch word address 0x40, no inst_valid for dropped word.
REQ-039 IFETCH_MISALIGN_EXC_EN, redirect_pc=0x102 -> fetch_fault=1, mem_req=0 until rst_n; without macro next fetch address word 0x40.
